// File: rtl/dmem_mmio_responder_if.sv
// CPU data-port bus between the core (master) and the memory/MMIO responder (slave).
// Read data is combinational from the address, so there are no handshake signals.
interface dmem_mmio_responder_if;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_we;
  logic        data_re;
  logic [31:0] data_rdata;

  modport master (
    output data_addr, data_wdata, data_we, data_re,
    input  data_rdata
  );

  modport slave (
    input  data_addr, data_wdata, data_we, data_re,
    output data_rdata
  );
endinterface

// File: rtl/dmem_mmio_responder.sv
// Data-side responder: zero-latency word RAM plus an MMIO block holding a console TX FIFO,
// a 64-bit cycle counter with a latched high half, and a write-once test-result register.
module dmem_mmio_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  dmem_mmio_responder_if.slave      bus,
  output logic                      con_valid,
  output logic [7:0]                con_data,
  input  logic                      con_ready,
  output logic                      test_done,
  output logic [31:0]               test_code
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned FW = $clog2(FIFO_DEPTH);
  localparam logic [FW:0] FIFO_FULL_CNT = FIFO_DEPTH[FW:0];

  // Register selects are word offsets, i.e. data_addr[7:2].
  localparam logic [5:0] REG_TX     = 6'h00;
  localparam logic [5:0] REG_STATUS = 6'h01;
  localparam logic [5:0] REG_CYC_LO = 6'h02;
  localparam logic [5:0] REG_CYC_HI = 6'h03;
  localparam logic [5:0] REG_TEST   = 6'h04;

  logic          is_mmio;
  logic          is_store;
  logic [5:0]    reg_sel;
  logic [AW-1:0] word_idx;
  logic          unused_addr_bits;

  assign is_mmio  = (bus.data_addr[31:28] == MMIO_BASE[31:28]);
  assign is_store = |bus.data_we;
  assign reg_sel  = bus.data_addr[7:2];
  assign word_idx = bus.data_addr[AW+1:2];
  // Address bits between the RAM index and the region select deliberately alias.
  assign unused_addr_bits = ^bus.data_addr;

  // ---------------------------------------------------------------- RAM
  logic [31:0] mem_q [DEPTH_WORDS];

  // NOTE: the RAM array has no reset branch: contents must survive rst, and a reset
  // port would stop the tools from mapping it onto block RAM.
  always_ff @(posedge clk) begin
    if (!is_mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.data_we[i]) mem_q[word_idx][8*i +: 8] <= bus.data_wdata[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------- console FIFO
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [FW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          fifo_empty, fifo_full;
  logic          push_req, push, pop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FIFO_FULL_CNT);
  assign push_req   = is_mmio && (reg_sel == REG_TX) && bus.data_we[0];
  assign pop        = !fifo_empty && con_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push       = push_req && (!fifo_full || pop);

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    rd_ptr_d   = rd_ptr_q + FW'(pop);
    wr_ptr_d   = wr_ptr_q + FW'(push);
    count_d    = count_q + (FW+1)'(push) - (FW+1)'(pop);
    overflow_d = overflow_q;
    if (is_mmio && (reg_sel == REG_STATUS) && is_store) overflow_d = 1'b0;
    if (push_req && !push)                               overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= bus.data_wdata[7:0];
  end

  assign con_valid = !fifo_empty;
  assign con_data  = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];

  // ---------------------------------------------------------------- control state
  logic [63:0] cycle_q;
  logic [31:0] hi_shadow_q;
  logic        test_done_q;
  logic [31:0] test_code_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      cycle_q     <= '0;
      hi_shadow_q <= '0;
      test_done_q <= 1'b0;
      test_code_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      cycle_q    <= cycle_q + 64'd1;
      // Reading the low half freezes the matching high half for a later CYCLE_HI read.
      if (is_mmio && (reg_sel == REG_CYC_LO) && bus.data_re) hi_shadow_q <= cycle_q[63:32];
      if (is_mmio && (reg_sel == REG_TEST) && is_store && !test_done_q) begin
        test_done_q <= 1'b1;
        test_code_q <= bus.data_wdata;
      end
    end
  end

  assign test_done = test_done_q;
  assign test_code = test_code_q;

  // ---------------------------------------------------------------- read mux
  always_comb begin
    bus.data_rdata = '0;
    if (is_mmio) begin
      case (reg_sel)
        REG_STATUS: bus.data_rdata = {29'b0, overflow_q, fifo_full, fifo_empty};
        REG_CYC_LO: bus.data_rdata = cycle_q[31:0];
        REG_CYC_HI: bus.data_rdata = hi_shadow_q;
        default:    bus.data_rdata = '0;
      endcase
    end else begin
      bus.data_rdata = mem_q[word_idx];
    end
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Self-checking bench for dmem_mmio_responder: table-driven RAM/MMIO vectors plus
// hand sequences for FIFO overflow, push/pop on full, cycle latch and mid-stream reset.
module tb_dmem_mmio_responder;

  localparam logic [31:0] A_TX     = 32'h1000_0000;
  localparam logic [31:0] A_STATUS = 32'h1000_0004;
  localparam logic [31:0] A_CYC_LO = 32'h1000_0008;
  localparam logic [31:0] A_CYC_HI = 32'h1000_000C;
  localparam logic [31:0] A_TEST   = 32'h1000_0010;

  logic        clk = 1'b0;
  logic        rst;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;
  logic        test_done;
  logic [31:0] test_code;

  dmem_mmio_responder_if bus ();

  dmem_mmio_responder #(
    .DEPTH_WORDS(4096),
    .MMIO_BASE  (32'h1000_0000),
    .FIFO_DEPTH (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .con_valid(con_valid),
    .con_data (con_data),
    .con_ready(con_ready),
    .test_done(test_done),
    .test_code(test_code)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        re;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                       input logic re);
    bus.data_addr  = a;
    bus.data_wdata = wd;
    bus.data_we    = we;
    bus.data_re    = re;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus cycle: drive, compare combinational read data mid-cycle, commit at the edge.
  task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                        input logic re, input logic chk, input logic [31:0] exp,
                        input string name);
    drive(a, wd, we, re);
    @(negedge clk);
    if (chk) check(name, {32'h0, bus.data_rdata}, {32'h0, exp});
    tick();
    drive(A_STATUS, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic push_byte(input logic [7:0] b, input logic accept);
    if (accept) exp_q.push_back(b);
    access(A_TX, {24'h0, b}, 4'b0001, 1'b0, 1'b0, 32'h0, "tx");
  endtask

  task automatic drain(input int expected);
    int p0;
    p0 = pops;
    con_ready = 1'b1;
    drive(A_STATUS, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 24 && con_valid; i++) tick();
    check("drain_count", 64'(pops - p0), 64'(expected));
    check("con_valid_after_drain", {63'h0, con_valid}, 64'h0);
  endtask

  // Scoreboard consumer: whatever the sink accepts must be the next expected byte.
  always @(negedge clk) begin
    if (!rst && con_valid && con_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL con_unexpected: got %h expected no byte", con_data);
      end else begin
        check("con_data", {56'h0, con_data}, {56'h0, exp_q.pop_front()});
        pops++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF,    1'b0, 1'b0, 32'h0};
    vecs[1]  = '{32'h0000_0010, 32'h0000_5500, 4'b0010, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{32'h0000_0010, 32'h0,         4'h0,    1'b1, 1'b1, 32'hDEAD_55EF};
    vecs[3]  = '{32'h0000_4010, 32'h0000_0011, 4'hF,    1'b0, 1'b1, 32'hDEAD_55EF};
    vecs[4]  = '{32'h0000_0010, 32'h0,         4'h0,    1'b1, 1'b1, 32'h0000_0011};
    vecs[5]  = '{32'h0000_0020, 32'h1234_5678, 4'hF,    1'b0, 1'b0, 32'h0};
    vecs[6]  = '{32'h0000_0020, 32'hAB00_0000, 4'b1000, 1'b0, 1'b1, 32'h1234_5678};
    vecs[7]  = '{32'h0000_0020, 32'h00CD_00EF, 4'b0101, 1'b0, 1'b1, 32'hAB34_5678};
    vecs[8]  = '{32'h1000_0020, 32'hFFFF_FFFF, 4'hF,    1'b0, 1'b1, 32'h0};
    vecs[9]  = '{32'h0000_0020, 32'h0,         4'h0,    1'b1, 1'b1, 32'hABCD_56EF};
    vecs[10] = '{32'hFFFF_3FFC, 32'hCAFE_F00D, 4'hF,    1'b0, 1'b0, 32'h0};
    vecs[11] = '{32'h0000_3FFC, 32'h0,         4'h0,    1'b1, 1'b1, 32'hCAFE_F00D};
    vecs[12] = '{32'h1000_0000, 32'h0,         4'h0,    1'b1, 1'b1, 32'h0};
    vecs[13] = '{32'h1000_0105, 32'h0,         4'h0,    1'b1, 1'b1, 32'h0000_0001};

    rst       = 1'b1;
    con_ready = 1'b0;
    drive(A_STATUS, 32'h0, 4'h0, 1'b0);
    repeat (2) tick();
    check("rst_con_valid", {63'h0, con_valid}, 64'h0);
    check("rst_con_data",  {56'h0, con_data},  64'h0);
    check("rst_test_done", {63'h0, test_done}, 64'h0);
    check("rst_test_code", {32'h0, test_code}, 64'h0);
    access(A_STATUS, 32'h0, 4'h0, 1'b0, 1'b1, 32'h1, "rst_status");
    access(A_CYC_LO, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, "rst_cycle_lo");

    // Cycle counter: after 100 non-reset edges it reads 100; reading LO latches HI.
    rst = 1'b0;
    drive(A_CYC_LO, 32'h0, 4'h0, 1'b0);
    repeat (100) tick();
    check("cycle_lo_at_100", {32'h0, bus.data_rdata}, 64'd100);
    drive(A_CYC_LO, 32'h0, 4'h0, 1'b1);
    tick();
    drive(A_CYC_LO, 32'h0, 4'h0, 1'b0);
    #1;
    check("cycle_lo_at_101", {32'h0, bus.data_rdata}, 64'd101);
    access(A_CYC_HI, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0, "cycle_hi_shadow");

    for (int i = 0; i < 14; i++) begin
      access(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].re, vecs[i].chk, vecs[i].exp,
             $sformatf("vec%0d", i));
    end

    // Write-once test-result register.
    access(A_TEST, 32'h1, 4'hF, 1'b0, 1'b0, 32'h0, "test_wr1");
    check("test_done_1", {63'h0, test_done}, 64'h1);
    check("test_code_1", {32'h0, test_code}, 64'h1);
    access(A_TEST, 32'h2, 4'hF, 1'b0, 1'b0, 32'h0, "test_wr2");
    check("test_code_kept", {32'h0, test_code}, 64'h1);

    // Overflow: nine pushes into eight slots with the sink stalled.
    con_ready = 1'b0;
    for (int i = 0; i < 9; i++) push_byte(8'(8'h41 + i), i < 8);
    access(A_STATUS, 32'h0, 4'h0, 1'b1, 1'b1, 32'h6, "status_ovf_full");
    check("head_byte", {56'h0, con_data}, 64'h41);
    drain(8);
    access(A_STATUS, 32'h0, 4'h0, 1'b1, 1'b1, 32'h5, "status_ovf_sticky");
    access(A_STATUS, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, "status_clear");
    access(A_STATUS, 32'h0, 4'h0, 1'b1, 1'b1, 32'h1, "status_empty");

    // Full FIFO with simultaneous push and pop: no drop, no overflow.
    con_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_byte(8'(8'h50 + i), 1'b1);
    access(A_STATUS, 32'h0, 4'h0, 1'b1, 1'b1, 32'h2, "status_full");
    con_ready = 1'b1;
    push_byte(8'h5A, 1'b1);
    access(A_STATUS, 32'h0, 4'h0, 1'b1, 1'b1, 32'h2, "status_full_pushpop");
    drain(7);
    check("scoreboard_empty_1", 64'(exp_q.size()), 64'h0);
    access(A_STATUS, 32'h0, 4'h0, 1'b1, 1'b1, 32'h1, "status_after_pushpop");

    // Reset mid-drain, with a same-cycle console store that must be discarded.
    con_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_byte(8'(8'h61 + i), 1'b1);
    con_ready = 1'b1;
    tick();
    con_ready = 1'b0;
    rst = 1'b1;
    drive(A_TX, 32'h70, 4'b0001, 1'b0);
    tick();
    exp_q.delete();
    check("midrst_con_valid", {63'h0, con_valid}, 64'h0);
    check("midrst_con_data",  {56'h0, con_data},  64'h0);
    check("midrst_test_done", {63'h0, test_done}, 64'h0);
    check("midrst_test_code", {32'h0, test_code}, 64'h0);
    rst = 1'b0;
    access(32'h0000_0010, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0000_0011, "ram_kept_over_rst");
    access(A_TEST, 32'h7, 4'hF, 1'b0, 1'b0, 32'h0, "test_wr_after_rst");
    check("test_done_rearm", {63'h0, test_done}, 64'h1);
    check("test_code_rearm", {32'h0, test_code}, 64'h7);
    check("scoreboard_empty_2", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
